// File: rtl/mem_rd_arbiter.sv
// rtl/mem_rd_arbiter.sv - round-robin arbiter sharing one memory read port among read clients
module mem_rd_arbiter #(
   parameter  int NUM_CLIENTS = 2,
   parameter  int ADDR_WIDTH  = 32,
   parameter  int SIZE_WIDTH  = 16,
   parameter  int DATA_WIDTH  = 128,
   localparam int OW          = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_CLIENTS-1:0]            cl_req,
   input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_start_addr,
   input  logic [NUM_CLIENTS*SIZE_WIDTH-1:0] cl_size_bytes,
   output logic [NUM_CLIENTS-1:0]            cl_gnt,
   output logic [DATA_WIDTH-1:0]             cl_data,
   output logic [NUM_CLIENTS-1:0]            cl_valid,
   output logic [NUM_CLIENTS-1:0]            cl_last,
   output logic                              mem_req,
   output logic [ADDR_WIDTH-1:0]             mem_start_addr,
   output logic [SIZE_WIDTH-1:0]             mem_size_bytes,
   input  logic                              mem_ack,
   input  logic [DATA_WIDTH-1:0]             mem_data,
   input  logic                              mem_valid,
   input  logic                              mem_last,
   output logic                              busy,
   output logic [OW-1:0]                     owner,
   output logic                              proto_err
);

   localparam int BPB = DATA_WIDTH / 8;
   localparam int CW  = SIZE_WIDTH + 1;
   localparam int PW  = OW + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, XFER, ZDONE} state_t;

   state_t                  state_q, state_d;
   logic [OW-1:0]           owner_q, owner_d;
   logic [OW-1:0]           rr_ptr_q, rr_ptr_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [SIZE_WIDTH-1:0]   size_q, size_d;
   logic [CW-1:0]           beats_exp_q, beats_exp_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    mem_req_q, mem_req_d;
   logic                    proto_err_q, proto_err_d;

   logic [2*NUM_CLIENTS-1:0] req_dbl;
   logic [NUM_CLIENTS-1:0]   req_rot;
   logic [PW-1:0]            pick_sum;
   logic [PW-1:0]            owner_sum;
   logic [OW-1:0]            pick;
   logic [OW-1:0]            owner_inc;
   logic [ADDR_WIDTH-1:0]    pick_addr;
   logic [SIZE_WIDTH-1:0]    pick_size;
   logic [CW-1:0]            pick_beats;
   logic                     any_req;
   logic                     final_beat;
   logic [NUM_CLIENTS-1:0]   owner_oh;

   // Rotate requests so rr_ptr lands on bit 0, take the lowest set bit, then un-rotate
   always_comb begin
      req_dbl  = {cl_req, cl_req} >> rr_ptr_q;
      req_rot  = req_dbl[NUM_CLIENTS-1:0];
      any_req  = |cl_req;
      pick_sum = '0;
      for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
         if (req_rot[k]) pick_sum = {1'b0, rr_ptr_q} + PW'(k);
      end
      if (pick_sum >= PW'(NUM_CLIENTS)) pick_sum = pick_sum - PW'(NUM_CLIENTS);
      pick = pick_sum[OW-1:0];
   end

   // Fields of the selected client and its beat count, ceil(size / bytes-per-beat)
   always_comb begin
      pick_addr = '0;
      pick_size = '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         if (pick == OW'(i)) begin
            pick_addr = cl_start_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            pick_size = cl_size_bytes[i*SIZE_WIDTH +: SIZE_WIDTH];
         end
      end
      pick_beats = (CW'(pick_size) + CW'(BPB - 1)) / CW'(BPB);
   end

   // Owner decode, final-beat detect and the pointer value handed on after completion
   always_comb begin
      final_beat = (cnt_q == beats_exp_q - CW'(1));
      owner_oh   = NUM_CLIENTS'(1) << owner_q;
      owner_sum  = {1'b0, owner_q} + PW'(1);
      if (owner_sum == PW'(NUM_CLIENTS)) owner_sum = '0;
      owner_inc  = owner_sum[OW-1:0];
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; the beat counter alone ends a transfer, mem_last is only checked
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = (pick_size == '0) ? ZDONE : ISSUE;
         ISSUE:   if (mem_ack) state_d = XFER;
         XFER:    if (mem_valid && final_beat) state_d = IDLE;
         ZDONE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Client-side outputs, one-hot to the current owner
   always_comb begin
      cl_gnt   = '0;
      cl_valid = '0;
      cl_last  = '0;
      case (state_q)
         ISSUE: if (mem_ack) cl_gnt = owner_oh;
         XFER: begin
            if (mem_valid)               cl_valid = owner_oh;
            if (mem_valid && final_beat) cl_last  = owner_oh;
         end
         ZDONE: begin
            cl_gnt  = owner_oh;
            cl_last = owner_oh;
         end
         default: ;
      endcase
   end

   // Datapath next state: request latch, beat counting, pointer advance, sticky error
   always_comb begin
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      addr_d      = addr_q;
      size_d      = size_q;
      beats_exp_d = beats_exp_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      proto_err_d = proto_err_q;
      case (state_q)
         IDLE: if (any_req) begin
            owner_d     = pick;
            addr_d      = pick_addr;
            size_d      = pick_size;
            beats_exp_d = pick_beats;
            mem_req_d   = (pick_size != '0);
         end
         ISSUE: if (mem_ack) begin
            mem_req_d = 1'b0;
            cnt_d     = '0;
         end
         XFER: if (mem_valid) begin
            cnt_d = cnt_q + CW'(1);
            if (final_beat) rr_ptr_d = owner_inc;
         end
         ZDONE:   rr_ptr_d = owner_inc;
         default: ;
      endcase
      if (mem_valid && state_q != XFER)  proto_err_d = 1'b1;
      if (mem_ack && state_q != ISSUE)   proto_err_d = 1'b1;
      if (state_q == XFER && mem_valid && (mem_last != final_beat)) proto_err_d = 1'b1;
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         addr_q      <= '0;
         size_q      <= '0;
         beats_exp_q <= '0;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         beats_exp_q <= beats_exp_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign cl_data        = mem_data;
   assign mem_req        = mem_req_q;
   assign mem_start_addr = addr_q;
   assign mem_size_bytes = size_q;
   assign busy           = (state_q != IDLE);
   assign owner          = owner_q;
   assign proto_err      = proto_err_q;

endmodule
